// File: rtl/keypad_scanner.sv
// keypad_scanner: frame-based 4x4 matrix keypad scanner with per-frame
// debounce and single-cycle key press events.
//
// Ports:
//   hwclk     in   system clock
//   rst       in   asynchronous active-high reset
//   keypad_r  out  row drives, active-low, one row low at a time
//   keypad_c  in   column sense lines, pulled up, low when pressed
//   key_valid out  one-cycle pulse on a newly committed press
//   key_code  out  row*4+col of the reported key, held between events
//   key_held  out  any key in the committed matrix
//   key_multi out  two or more keys in the committed matrix

module keypad_scanner #(
  parameter int SCAN_DIV = 3000,
  parameter int DEBOUNCE = 4
) (
  input  logic       hwclk,
  input  logic       rst,
  output logic [3:0] keypad_r,
  input  logic [3:0] keypad_c,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       key_multi
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DB_MAX   = SW'(DEBOUNCE);

  // index of the lowest set bit; the lowest code wins on a tie
  function automatic logic [3:0] lsb_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [DW-1:0] div_cnt;
  logic [1:0]    row_idx;
  logic [15:0]   snap;
  logic [15:0]   prev_snap;
  logic [15:0]   committed;
  logic [SW-1:0] stable_cnt;

  logic          dwell_end;
  logic          frame_end;
  logic [1:0]    row_nxt;
  logic [3:0]    pressed;
  logic [15:0]   new_snap;
  logic [SW-1:0] stable_nxt;
  logic          commit;
  logic [15:0]   rise;

  assign dwell_end = (div_cnt == DIV_LAST);
  assign frame_end = dwell_end && (row_idx == 2'd3);
  assign row_nxt   = row_idx + 2'd1;
  assign pressed   = ~sync2;

  // the row-3 sample lands in snap on the same edge as the frame
  // compare, so the compare uses it directly
  always_comb begin
    new_snap = snap;
    new_snap[15:12] = pressed;
  end

  always_comb begin
    stable_nxt = '0;
    if (new_snap == prev_snap) begin
      if (stable_cnt == DB_MAX) stable_nxt = stable_cnt;
      else stable_nxt = stable_cnt + 1'b1;
    end
  end

  assign commit = (stable_nxt == DB_MAX);
  assign rise   = new_snap & ~committed;

  // column synchronizer, idle value is all released
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= keypad_c;
      sync2 <= sync1;
    end
  end

  // row scan: dwell SCAN_DIV cycles per row, sample at end of dwell
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      row_idx  <= 2'd0;
      keypad_r <= 4'b1110;
      snap     <= '0;
    end else begin
      if (dwell_end) begin
        div_cnt  <= '0;
        row_idx  <= row_nxt;
        keypad_r <= ~(4'b0001 << row_nxt);
        snap[{row_idx, 2'b00} +: 4] <= pressed;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // frame debounce and event generation
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      prev_snap  <= '0;
      stable_cnt <= '0;
      committed  <= '0;
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
      key_held   <= 1'b0;
      key_multi  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        prev_snap  <= new_snap;
        stable_cnt <= stable_nxt;
        if (commit) begin
          committed <= new_snap;
          key_held  <= |new_snap;
          key_multi <= (popcount(new_snap) >= 5'd2);
          if (|rise) begin
            key_valid <= 1'b1;
            key_code  <= lsb_index(rise);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural
// keypad matrix model (SCAN_DIV=4, DEBOUNCE=2, 16-cycle frames).

module tb_keypad_scanner;

  logic        hwclk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keypad_r;
  logic [3:0]  keypad_c;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic        key_multi;

  logic [15:0] keys = 16'h0;
  int          cyc;
  int          total = 0;
  int          bad = 0;
  int          ev_cyc[$];
  logic [3:0]  ev_code[$];
  logic        prev_kv = 1'b0;
  logic [3:0]  rtab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 hwclk = ~hwclk;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(2)
  ) dut (
    .hwclk(hwclk),
    .rst(rst),
    .keypad_r(keypad_r),
    .keypad_c(keypad_c),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held),
    .key_multi(key_multi)
  );

  // matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    keypad_c = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !keypad_r[r]) keypad_c[c] = 1'b0;
      end
    end
  end

  always @(posedge hwclk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge hwclk) begin
    if (rst) begin
      prev_kv = 1'b0;
    end else begin
      total++;
      assert (!(key_valid && prev_kv)) else begin
        bad++;
        $error("FAIL kv_double observed=1 expected=0 cyc=%0d", cyc);
      end
      if (key_valid) begin
        ev_cyc.push_back(cyc);
        ev_code.push_back(key_code);
      end
      prev_kv = key_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic go(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge hwclk);
      n++;
    end
    chk("cyc_sync", cyc, target);
  endtask

  task automatic do_reset(input logic [15:0] k);
    @(negedge hwclk);
    rst = 1'b1;
    keys = k;
    @(negedge hwclk);
    @(negedge hwclk);
    ev_cyc.delete();
    ev_code.delete();
    rst = 1'b0;
  endtask

  initial begin
    // reset values and idle scanning
    keys = 16'h0;
    rst = 1'b1;
    @(negedge hwclk);
    @(negedge hwclk);
    chk("rst_r", keypad_r, 4'b1110);
    chk("rst_kv", key_valid, 1'b0);
    chk("rst_code", key_code, 4'd0);
    chk("rst_held", key_held, 1'b0);
    chk("rst_multi", key_multi, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      go(i);
      chk("idle_r", keypad_r, rtab[(i / 4) % 4]);
      chk("idle_kv", key_valid, 1'b0);
    end
    chk("idle_held", key_held, 1'b0);
    chk("idle_multi", key_multi, 1'b0);
    chk("idle_code", key_code, 4'd0);

    // single press of key 6 (row 1, col 2)
    do_reset(16'h0040);
    go(47);
    chk("sp_kv_early", key_valid, 1'b0);
    chk("sp_held_early", key_held, 1'b0);
    go(48);
    chk("sp_kv", key_valid, 1'b1);
    chk("sp_code", key_code, 4'd6);
    chk("sp_held", key_held, 1'b1);
    chk("sp_multi", key_multi, 1'b0);
    go(49);
    chk("sp_kv_after", key_valid, 1'b0);
    chk("sp_code_hold", key_code, 4'd6);
    go(64);
    keys = 16'h0;
    go(111);
    chk("rel_held_early", key_held, 1'b1);
    go(112);
    chk("rel_held", key_held, 1'b0);
    chk("rel_kv", key_valid, 1'b0);
    go(130);
    chk("sp_events", ev_cyc.size(), 1);

    // bounce on key 6, then hold
    do_reset(16'h0);
    go(20);  keys = 16'h0040;
    go(40);  keys = 16'h0;
    go(60);  keys = 16'h0040;
    go(80);  keys = 16'h0;
    go(100); keys = 16'h0040;
    go(143);
    chk("bn_quiet", ev_cyc.size(), 0);
    chk("bn_kv_early", key_valid, 1'b0);
    go(144);
    chk("bn_kv", key_valid, 1'b1);
    chk("bn_code", key_code, 4'd6);
    go(160);
    chk("bn_events", ev_cyc.size(), 1);

    // two keys: 9 and 3 together, then release 3
    do_reset(16'h0208);
    go(47);
    chk("tk_multi_early", key_multi, 1'b0);
    go(48);
    chk("tk_kv", key_valid, 1'b1);
    chk("tk_code", key_code, 4'd3);
    chk("tk_multi", key_multi, 1'b1);
    chk("tk_held", key_held, 1'b1);
    go(64);
    keys = 16'h0200;
    go(111);
    chk("tk_multi_hold", key_multi, 1'b1);
    go(112);
    chk("tk_multi_rel", key_multi, 1'b0);
    chk("tk_held_rel", key_held, 1'b1);
    chk("tk_code_rel", key_code, 4'd3);
    go(130);
    chk("tk_events", ev_cyc.size(), 1);

    // sequence 1,2,1,1 with 5-frame press/release phases
    do_reset(16'h0002);
    go(80);  keys = 16'h0;
    go(160); keys = 16'h0004;
    go(240); keys = 16'h0;
    go(320); keys = 16'h0002;
    go(400); keys = 16'h0;
    go(480); keys = 16'h0002;
    go(560); keys = 16'h0;
    go(630);
    chk("seq_count", ev_cyc.size(), 4);
    if (ev_cyc.size() == 4) begin
      chk("seq_c0", ev_code[0], 4'd1);
      chk("seq_c1", ev_code[1], 4'd2);
      chk("seq_c2", ev_code[2], 4'd1);
      chk("seq_c3", ev_code[3], 4'd1);
      chk("seq_t0", ev_cyc[0], 48);
      chk("seq_t1", ev_cyc[1], 208);
      chk("seq_t2", ev_cyc[2], 368);
      chk("seq_t3", ev_cyc[3], 528);
    end

    // reset during the key_valid cycle and during row 2 dwell
    do_reset(16'h0040);
    go(48);
    chk("mr_kv_pre", key_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mr_kv", key_valid, 1'b0);
    chk("mr_held", key_held, 1'b0);
    chk("mr_code", key_code, 4'd0);
    chk("mr_r", keypad_r, 4'b1110);
    @(negedge hwclk);
    rst = 1'b0;
    go(9);
    chk("mr_row2", keypad_r, 4'b1011);
    rst = 1'b1;
    #1;
    chk("mr_r2", keypad_r, 4'b1110);
    @(negedge hwclk);
    ev_cyc.delete();
    ev_code.delete();
    rst = 1'b0;
    go(4);
    chk("mr_r_row1", keypad_r, 4'b1101);
    go(47);
    chk("mr_kv_early", key_valid, 1'b0);
    go(48);
    chk("mr_kv_again", key_valid, 1'b1);
    chk("mr_code_again", key_code, 4'd6);
    go(60);
    chk("mr_events", ev_cyc.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one row low at a time and sampling the four column lines. The sampled matrix is debounced per scan frame, and each new key press becomes a single-cycle event carrying a 4-bit key code. It sits between the keypad pins and the sequence-detector FSMs, producing the press pulses those FSMs consume. It replaces per-button debouncers with one frame-based scanner.

## Interface
- SCAN_DIV, 3000: clock cycles each row is driven (dwell); must be >= 4. At 12 MHz, 3000 gives 1 ms per frame.
- DEBOUNCE, 4: consecutive identical frame comparisons required before a matrix state is committed; must be >= 1.
- hwclk  in  1  system clock (12 MHz).
- rst  in  1  reset, asynchronous, active-high.
- keypad_r  out  4  row drives, active-low, exactly one bit low at any time.
- keypad_c  in  4  column inputs, externally pulled up; a pressed key pulls its column low.
- key_valid  out  1  one-cycle pulse on a newly committed press.
- key_code  out  4  code of the reported key = row*4 + col; held until the next event.
- key_held  out  1  high while any key is in the committed state.
- key_multi  out  1  high while two or more keys are in the committed state.

## Operation
- keypad_c passes through a 2-flop synchronizer. Pressed bits are ~col_sync.
- Counters:
  - div_cnt counts 0..SCAN_DIV-1.
  - row_idx counts 0..3 and advances when div_cnt wraps; it wraps from 3 to 0.
  - keypad_r = ~(1 << row_idx), registered.
- Sampling: when div_cnt == SCAN_DIV-1, snap[row_idx*4 +: 4] <= ~col_sync. This gives the synchronizer and pin settle time within the dwell.
- Frame end is the cycle with row_idx == 3 and div_cnt == SCAN_DIV-1. new_snap is snap with row 3 replaced by the current sample. On that clock edge:
  - If new_snap == prev_snap: stable_cnt <= min(stable_cnt+1, DEBOUNCE). Otherwise stable_cnt <= 0.
  - prev_snap <= new_snap.
  - If the resulting stable_cnt == DEBOUNCE:
    - committed <= new_snap.
    - rise = new_snap & ~committed.
    - If rise != 0: key_valid <= 1 and key_code <= index of the lowest set bit of rise.
- Simultaneous new presses in one commit: only the lowest code is reported. The others enter committed silently and do not generate later events while held.
- Releases update committed and generate no event.
- A bounce (snapshot change) in any frame resets stable_cnt to 0, so the debounce window restarts.
- key_held = |committed. key_multi = popcount(committed) >= 2. Both are registered, updating on the commit edge.
- No ghost suppression: the raw matrix is reported as scanned.

## Timing
- Reset values:
  - keypad_r = 4'b1110.
  - div_cnt, row_idx, stable_cnt = 0.
  - snap, prev_snap, committed = 0.
  - key_valid, key_code, key_held, key_multi = 0.
  - Synchronizer flops = 4'b1111 (released).
- Reset asserted mid-frame or mid-pulse clears all state immediately. Scanning restarts at row 0 on the first edge after deassert.
- Frame length is 4*SCAN_DIV cycles.
- key_valid is high for exactly one cycle: the cycle after the frame-end edge. It is never high in two consecutive cycles.
- Press latency, for a key stable at the pins from before a frame start with prev_snap = 0: the event comes at the (DEBOUNCE+1)th frame end containing the key. key_valid is asserted 1 cycle after that edge.
- Release latency is the same frame count, measured on key_held falling.
- Row changes on keypad_r occur on the edge where div_cnt wraps.

## Test plan
- Reset/idle (SCAN_DIV=4, DEBOUNCE=2, no keys): keypad_r cycles 1110→1101→1011→0111 every 4 cycles, repeating with period 16; key_valid, key_held, key_multi stay 0; key_code = 0.
- Single press: hold row1/col2 (keypad_c[2] low while keypad_r[1] low) from frame 0 → key_valid pulses once, 1 cycle after the 3rd frame end, with key_code = 6 and key_held = 1. On release, key_held falls after 3 frames and no pulse is produced.
- Bounce: toggle key 6 every 20 cycles for 100 cycles, then hold → no key_valid during toggling; exactly one pulse (code 6) 3 frames after the hold begins.
- Two keys: hold codes 9 and 3 together → one pulse with key_code = 3; key_multi = 1; releasing 3 while holding 9 produces no pulse and key_multi = 0.
- Sequence 1,2,1,1 (codes 1,2,1,1), each pressed for 5 frames with 5 frames released between → exactly four pulses with codes 1,2,1,1, in that order.
- Reset mid-operation: assert rst during the key_valid cycle and during row 2 dwell → outputs go to reset values immediately; after deassert, keypad_r = 1110 and a held key reports again after 3 frames.
